// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin grant of one header per packet onto a shared insert datapath.
// Define HDR_ARB_TIMEOUT_EN to add a watchdog that abandons a grant after TIMEOUT_CYC cycles.
module axi_stream_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 4,
    parameter int SRC_ID_WD    = $clog2(NUM_SRC),
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              req_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_SRC-1:0]              req_ready,
    output logic                            hdr_valid,
    output logic [DATA_WD-1:0]              hdr_data,
    output logic [DATA_BYTE_WD-1:0]         hdr_keep,
    output logic [BYTE_CNT_WD-1:0]          hdr_byte_cnt,
    input  logic                            hdr_ready,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [SRC_ID_WD-1:0]            grant_id,
    output logic                            busy,
    output logic [15:0]                     pkt_cnt,
    output logic                            timeout
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_EOP} state_t;
    state_t state, state_nxt;
    logic [SRC_ID_WD-1:0] rr_ptr, win, nxt_ptr;
    logic any_req, grant, done, expire;
    assign any_req = |req_valid;
    assign grant = state == IDLE && any_req;
    assign done = state == WAIT_EOP && mon_valid && mon_ready && mon_last;
    assign nxt_ptr = (grant_id == SRC_ID_WD'(NUM_SRC - 1)) ? '0 : grant_id + SRC_ID_WD'(1);
    assign hdr_valid = state == SEND;
    assign busy = state != IDLE;
    assign timeout = expire;
    // Highest offset first so the lowest offset from rr_ptr ends up as the winner.
    always_comb begin
        win = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (req_valid[(int'(rr_ptr) + k) % NUM_SRC]) win = SRC_ID_WD'((int'(rr_ptr) + k) % NUM_SRC);
    end
    always_comb begin
        req_ready = '0;
        req_ready[win] = grant && !rst;
    end
`ifdef HDR_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt <= '0;
        else to_cnt <= (state == IDLE) ? '0 : to_cnt + TW'(1);
    end
    // A completing eop in the limit cycle takes precedence over the watchdog.
    assign expire = busy && to_cnt == TW'(TIMEOUT_CYC) && !done;
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (grant) state_nxt = SEND;
        if (state == SEND && hdr_ready) state_nxt = WAIT_EOP;
        if (done || expire) state_nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            grant_id <= '0;
            hdr_data <= '0;
            hdr_keep <= '0;
            hdr_byte_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            if (grant) begin
                grant_id <= win;
                hdr_data <= req_data[win*DATA_WD +: DATA_WD];
                hdr_keep <= req_keep[win*DATA_BYTE_WD +: DATA_BYTE_WD];
                hdr_byte_cnt <= req_byte_cnt[win*BYTE_CNT_WD +: BYTE_CNT_WD];
            end
            if (done) pkt_cnt <= pkt_cnt + 16'd1;
            if (done || expire) rr_ptr <= nxt_ptr;
        end
    end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb_axi_stream_header_arbiter: randomized scenarios checked against a round-robin reference model.
module tb_axi_stream_header_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_valid;
    logic [127:0] req_data;
    logic [15:0] req_keep;
    logic [7:0] req_byte_cnt;
    logic [3:0] req_ready;
    logic hdr_valid;
    logic [31:0] hdr_data;
    logic [3:0] hdr_keep;
    logic [1:0] hdr_byte_cnt;
    logic hdr_ready, mon_valid, mon_ready, mon_last;
    logic [1:0] grant_id;
    logic busy;
    logic [15:0] pkt_cnt;
    logic timeout;
    int total = 0;
    int bad = 0;
    int m_rr, m_pkt;

    always #5 clk = ~clk;

    axi_stream_header_arbiter #(.DATA_WD(32), .NUM_SRC(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
        .req_byte_cnt(req_byte_cnt), .req_ready(req_ready), .hdr_valid(hdr_valid), .hdr_data(hdr_data),
        .hdr_keep(hdr_keep), .hdr_byte_cnt(hdr_byte_cnt), .hdr_ready(hdr_ready), .mon_valid(mon_valid),
        .mon_ready(mon_ready), .mon_last(mon_last), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt),
        .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(int rr, logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        return 0;
    endfunction

    task automatic do_packet(input logic [3:0] v, input int stall, input int beats, input bit rnd, output int w);
        logic [31:0] ed;
        logic [3:0] ek;
        logic [1:0] eb;
        int b, tries;
        bit mr;
        if (rnd) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            req_keep = 16'($urandom);
            req_byte_cnt = 8'($urandom);
        end
        w = pick(m_rr, v);
        ed = req_data[w*32 +: 32];
        ek = req_keep[w*4 +: 4];
        eb = req_byte_cnt[w*2 +: 2];
        req_valid = v;
        @(negedge clk);
        total++;
        if (req_ready !== 4'(1 << w)) begin
            bad++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, 4'(1 << w));
        end
        tick();
        req_valid = '0;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        total++;
        if (hdr_valid !== 1'b1 || hdr_data !== ed || hdr_keep !== ek || hdr_byte_cnt !== eb || grant_id !== 2'(w)) begin
            bad++;
            $display("FAIL header: valid=%b data=%h keep=%h cnt=%0d id=%0d expected 1 %h %h %0d %0d",
                     hdr_valid, hdr_data, hdr_keep, hdr_byte_cnt, grant_id, ed, ek, eb, w);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            @(negedge clk);
            total++;
            if (hdr_valid !== 1'b1 || hdr_data !== ed || req_ready !== 4'b0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL stall: valid=%b data=%h ready=%b to=%b expected 1 %h 0000 0",
                         hdr_valid, hdr_data, req_ready, timeout, ed);
            end
        end
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        @(negedge clk);
        total++;
        if (hdr_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL accept: hdr_valid=%b busy=%b expected 0 1", hdr_valid, busy);
        end
        b = 0;
        tries = 0;
        while (b < beats) begin
            mr = ($urandom_range(0, 3) != 0) || tries >= 4;
            mon_valid = 1'b1;
            mon_ready = mr;
            mon_last = (b == beats - 1);
            tick();
            tries++;
            if (mr) b++;
        end
        {mon_valid, mon_ready, mon_last} = '0;
        m_pkt = (m_pkt + 1) & 'hFFFF;
        m_rr = (w + 1) % 4;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pkt_cnt !== 16'(m_pkt)) begin
            bad++;
            $display("FAIL eop: busy=%b pkt_cnt=%0d expected 0 %0d", busy, pkt_cnt, m_pkt);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        req_data = '1;
        req_keep = '1;
        req_byte_cnt = '1;
        {hdr_ready, mon_valid, mon_ready, mon_last} = '0;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 4'b0 || hdr_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: ready=%b valid=%b busy=%b to=%b expected all 0", req_ready, hdr_valid, busy, timeout);
        end
        total++;
        if (hdr_data !== 32'h0 || hdr_keep !== 4'h0 || hdr_byte_cnt !== 2'h0 || grant_id !== 2'h0 || pkt_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_regs: data=%h keep=%h cnt=%0d id=%0d pkt=%0d expected all 0",
                     hdr_data, hdr_keep, hdr_byte_cnt, grant_id, pkt_cnt);
        end
        req_valid = '0;
        tick();
        rst = 1'b0;
        m_rr = 0;
        m_pkt = 0;
        tick();
    endtask

    task automatic test_single();
        int w;
        req_data = '0;
        req_data[64 +: 32] = 32'hA5A5_0102;
        req_keep = 16'h0F00;
        req_byte_cnt = 8'b00_10_00_00;
        do_packet(4'b0100, 1, 2, 1'b0, w);
        total++;
        if (w != 2 || m_rr != 3) begin
            bad++;
            $display("FAIL single: winner=%0d expected 2", w);
        end
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hdr_valid !== 1'b0 || grant_id !== 2'd0 || pkt_cnt !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: busy=%b valid=%b id=%0d pkt=%0d expected 0 0 0 0", busy, hdr_valid, grant_id, pkt_cnt);
        end
        tick();
        rst = 1'b0;
        m_rr = 0;
        m_pkt = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int got[5];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) do_packet(4'hF, 0, 3, 1'b1, got[i]);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got[i] != exp_seq[i]) begin
                bad++;
                $display("FAIL rr_order[%0d]: grant=%0d expected %0d", i, got[i], exp_seq[i]);
            end
        end
        total++;
        if (pkt_cnt !== 16'd5) begin
            bad++;
            $display("FAIL rr_count: pkt_cnt=%0d expected 5", pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        int w;
        do_packet(4'b1010, 6, 2, 1'b1, w);
    endtask

    task automatic test_eop_concurrent();
        req_valid = 4'b0001;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL conc_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0 || grant_id !== 2'd0 || hdr_valid !== 1'b1) begin
            bad++;
            $display("FAIL conc_send: ready=%b id=%0d valid=%b expected 0000 0 1", req_ready, grant_id, hdr_valid);
        end
        hdr_ready = 1'b1;
        {mon_valid, mon_ready, mon_last} = 3'b111;
        tick();
        hdr_ready = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0 || busy !== 1'b1 || pkt_cnt !== 16'(m_pkt)) begin
            bad++;
            $display("FAIL conc_eop_cycle: ready=%b busy=%b pkt=%0d expected 0000 1 %0d", req_ready, busy, pkt_cnt, m_pkt);
        end
        tick();
        {mon_valid, mon_ready, mon_last} = '0;
        m_pkt = (m_pkt + 1) & 'hFFFF;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001 || busy !== 1'b0 || pkt_cnt !== 16'(m_pkt)) begin
            bad++;
            $display("FAIL conc_regrant: ready=%b busy=%b pkt=%0d expected 0001 0 %0d", req_ready, busy, pkt_cnt, m_pkt);
        end
        tick();
        req_valid = '0;
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        {mon_valid, mon_ready, mon_last} = 3'b111;
        tick();
        {mon_valid, mon_ready, mon_last} = '0;
        m_pkt = (m_pkt + 1) & 'hFFFF;
        m_rr = 1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pkt_cnt !== 16'(m_pkt)) begin
            bad++;
            $display("FAIL conc_done: busy=%b pkt=%0d expected 0 %0d", busy, pkt_cnt, m_pkt);
        end
        tick();
    endtask

    task automatic test_wrap();
        int w;
        force dut.pkt_cnt = 16'hFFFE;
        #1;
        release dut.pkt_cnt;
        m_pkt = 'hFFFE;
        @(negedge clk);
        total++;
        if (pkt_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL wrap_preload: pkt_cnt=%h expected fffe", pkt_cnt);
        end
        tick();
        do_packet(4'b0110, 0, 1, 1'b1, w);
        do_packet(4'b1001, 1, 2, 1'b1, w);
        total++;
        if (pkt_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap: pkt_cnt=%h expected 0000", pkt_cnt);
        end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 20; i++)
            do_packet(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 3), 1'b1, w);
    endtask

`ifdef HDR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int pkt0;
        pkt0 = m_pkt;
        req_valid = 4'b0010;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL to_grant: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b0111;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if (timeout !== (k == 16) || hdr_valid !== 1'b1) begin
                bad++;
                $display("FAIL to_pulse[%0d]: timeout=%b valid=%b expected %b 1", k, timeout, hdr_valid, k == 16);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100 || hdr_valid !== 1'b0 || timeout !== 1'b0 || pkt_cnt !== 16'(pkt0)) begin
            bad++;
            $display("FAIL to_after: ready=%b valid=%b to=%b pkt=%0d expected 0100 0 0 %0d",
                     req_ready, hdr_valid, timeout, pkt_cnt, pkt0);
        end
        tick();
        m_rr = 2;
        do_packet(4'b0111, 0, 1, 1'b1, w);
    endtask
`else
    task automatic test_timeout();
        int w;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || timeout !== 1'b0 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL no_timeout: busy=%b timeout=%b id=%0d expected 1 0 1", busy, timeout, grant_id);
        end
        {mon_valid, mon_ready, mon_last} = 3'b111;
        tick();
        {mon_valid, mon_ready, mon_last} = '0;
        m_pkt = (m_pkt + 1) & 'hFFFF;
        m_rr = 2;
        tick();
        do_packet(4'b0111, 0, 1, 1'b1, w);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_async_reset();
        test_round_robin();
        test_backpressure();
        test_eop_concurrent();
        test_wrap();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
